// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_pkg;

  typedef logic [3:0] state_t;
  typedef logic [3:0] alu_op_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_EXE_R  = 4'd2;
  localparam state_t S_WB_R   = 4'd3;
  localparam state_t S_EXE_I  = 4'd4;
  localparam state_t S_WB_I   = 4'd5;
  localparam state_t S_EXE_LS = 4'd6;
  localparam state_t S_MEM_RD = 4'd7;
  localparam state_t S_WB_LD  = 4'd8;
  localparam state_t S_MEM_WR = 4'd9;
  localparam state_t S_BR     = 4'd10;
  localparam state_t S_JMP    = 4'd11;
  localparam state_t S_ERR    = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam alu_op_t ALU_ADD = 4'd0;
  localparam alu_op_t ALU_SUB = 4'd1;
  localparam alu_op_t ALU_AND = 4'd2;
  localparam alu_op_t ALU_OR  = 4'd3;
  localparam alu_op_t ALU_XOR = 4'd4;
  localparam alu_op_t ALU_NOR = 4'd5;
  localparam alu_op_t ALU_SLT = 4'd6;
  localparam alu_op_t ALU_SLL = 4'd7;
  localparam alu_op_t ALU_SRL = 4'd8;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_RS    = 2'b01;
  localparam logic [1:0] PC_BR    = 2'b10;
  localparam logic [1:0] PC_JMP   = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_JAL = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - opcode/funct to ALU function code and legality flag
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_XOR: alu_op = ALU_XOR;
          FN_NOR: alu_op = ALU_NOR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SLL: alu_op = ALU_SLL;
          FN_SRL: alu_op = ALU_SRL;
          FN_JR:  alu_op = ALU_ADD;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:              alu_op = ALU_ADD;
      OP_SLTI:              alu_op = ALU_SLT;
      OP_ANDI:              alu_op = ALU_AND;
      OP_ORI:               alu_op = ALU_OR;
      OP_XORI:              alu_op = ALU_XOR;
      OP_BEQ, OP_BNE:       alu_op = ALU_SUB;
      OP_LW, OP_SW:         alu_op = ALU_ADD;
      OP_J, OP_JAL:         alu_op = ALU_ADD;
      default:              legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with Moore-decoded datapath strobes
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [4:0] JAL_REG      = 5'd31,
  parameter bit         TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  output logic [1:0] PC_s,
  output logic       PC_write,
  output logic       IR_write,
  output logic       Reg_Write,
  output logic       Mem_Write,
  output logic [1:0] rd_s,
  output logic [1:0] w_data_s,
  output logic [1:0] alu_srcb,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  // The jal link register index is wired into the datapath's rd_s=10 mux input.
  if (JAL_REG != 5'd31) begin : g_custom_jal_reg
  end

  state_t  cur_state, nxt_state;
  alu_op_t dec_alu_op;
  logic    dec_legal;
  logic    br_taken;

  mc_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  assign br_taken = ((opcode == OP_BEQ) & zf) | ((opcode == OP_BNE) & ~zf);
  assign state    = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = en ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!dec_legal) nxt_state = S_ERR;
        else begin
          case (opcode)
            OP_R:           nxt_state = (funct == FN_JR) ? S_JMP : S_EXE_R;
            OP_J, OP_JAL:   nxt_state = S_JMP;
            OP_BEQ, OP_BNE: nxt_state = S_BR;
            OP_LW, OP_SW:   nxt_state = S_EXE_LS;
            default:        nxt_state = S_EXE_I;
          endcase
        end
      end
      S_EXE_R:  nxt_state = S_WB_R;
      S_EXE_I:  nxt_state = S_WB_I;
      S_EXE_LS: nxt_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: nxt_state = S_WB_LD;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted instruction writes nothing.
  always_comb begin
    PC_s      = PC_PLUS4;
    PC_write  = 1'b0;
    IR_write  = 1'b0;
    Reg_Write = 1'b0;
    Mem_Write = 1'b0;
    rd_s      = RD_RT;
    w_data_s  = WD_ALU;
    alu_srcb  = SRCB_RT;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    if (rst_n) begin
      case (cur_state)
        S_FETCH:  IR_write = en;
        S_EXE_R:  alu_op = dec_alu_op;
        S_WB_R: begin
          Reg_Write = 1'b1;
          rd_s      = RD_RD;
          PC_write  = 1'b1;
        end
        S_EXE_I: begin
          alu_op   = dec_alu_op;
          alu_srcb = ((opcode == OP_ADDI) || (opcode == OP_SLTI)) ? SRCB_SEXT : SRCB_ZEXT;
        end
        S_WB_I, S_WB_LD: begin
          Reg_Write = 1'b1;
          PC_write  = 1'b1;
          w_data_s  = (cur_state == S_WB_LD) ? WD_MEM : WD_ALU;
        end
        S_EXE_LS: alu_srcb = SRCB_SEXT;
        S_MEM_WR: begin
          Mem_Write = 1'b1;
          PC_write  = 1'b1;
        end
        S_BR: begin
          alu_op   = ALU_SUB;
          PC_write = 1'b1;
          PC_s     = br_taken ? PC_BR : PC_PLUS4;
        end
        S_JMP: begin
          PC_write = 1'b1;
          PC_s     = (opcode == OP_R) ? PC_RS : PC_JMP;
          if (opcode == OP_JAL) begin
            Reg_Write = 1'b1;
            rd_s      = RD_JAL;
            w_data_s  = WD_PC;
          end
        end
        S_ERR: begin
          PC_write = 1'b1;
          illegal  = TRAP_ILLEGAL;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl: per-cycle expected outputs queued then compared
module tb_mc_ctrl;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] pc_s;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] rd_s;
    logic [1:0] w_data_s;
    logic [1:0] alu_srcb;
    logic [3:0] alu_op;
    logic       illegal;
  } rec_t;

  logic       clk, rst_n, en, zf;
  logic [5:0] opcode, funct;
  logic [1:0] PC_s, rd_s, w_data_s, alu_srcb;
  logic       PC_write, IR_write, Reg_Write, Mem_Write, illegal;
  logic [3:0] alu_op, state;

  rec_t  sb[$];
  string tags[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .funct(funct), .zf(zf),
    .PC_s(PC_s), .PC_write(PC_write), .IR_write(IR_write), .Reg_Write(Reg_Write),
    .Mem_Write(Mem_Write), .rd_s(rd_s), .w_data_s(w_data_s), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(logic [3:0] st, logic [1:0] pcs, logic pcw, logic irw,
                              logic rw, logic mw, logic [1:0] rd, logic [1:0] wd,
                              logic [1:0] srcb, logic [3:0] op, logic ill);
    rec_t r;
    r.st = st; r.pc_s = pcs; r.pc_write = pcw; r.ir_write = irw;
    r.reg_write = rw; r.mem_write = mw; r.rd_s = rd; r.w_data_s = wd;
    r.alu_srcb = srcb; r.alu_op = op; r.illegal = ill;
    return r;
  endfunction

  function automatic rec_t cur_obs();
    return mk(state, PC_s, PC_write, IR_write, Reg_Write, Mem_Write,
              rd_s, w_data_s, alu_srcb, alu_op, illegal);
  endfunction

  task automatic push(string tag, rec_t r);
    sb.push_back(r);
    tags.push_back(tag);
  endtask

  task automatic sample(output rec_t o);
    @(negedge clk);
    o = cur_obs();
  endtask

  task automatic push_fetch_decode(string tag);
    push({tag, "_fetch"},  mk(S_FETCH,  2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
    push({tag, "_decode"}, mk(S_DECODE, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
  endtask

  task automatic test_reset();
    rec_t obs, exp;
    rec_t rst_rec;
    string tag;
    rst_rec = mk(S_FETCH, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0);
    push("reset_state", rst_rec);
    sample(obs);
    exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s: got %h want %h", tag, obs, exp); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (IR_write !== 1'b1) begin n_fail++; $display("FAIL release_ir_write: got %b want 1", IR_write); end
    push("rst_add_decode", mk(S_DECODE, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
    push("rst_add_exe_r",  mk(S_EXE_R,  2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
    repeat (2) begin
      sample(obs);
      exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s: got %h want %h", tag, obs, exp); end
    end
    rst_n = 1'b0;
    #1;
    obs = cur_obs(); n_checks++;
    if (obs !== rst_rec) begin n_fail++; $display("FAIL abort_mid_exe_r: got %h want %h", obs, rst_rec); end
    @(posedge clk); #1;
    obs = cur_obs(); n_checks++;
    if (obs !== rst_rec) begin n_fail++; $display("FAIL held_reset: got %h want %h", obs, rst_rec); end
    rst_n = 1'b1;
  endtask

  task automatic test_r_type();
    logic [5:0] fn_tab[4] = '{FN_ADD, FN_SUB, FN_SLL, FN_NOR};
    logic [3:0] op_tab[4] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_NOR};
    rec_t obs, exp;
    string tag;
    for (int i = 0; i < 4; i++) begin
      opcode = OP_R; funct = fn_tab[i];
      push_fetch_decode("rtype");
      push("rtype_exe_r", mk(S_EXE_R, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, op_tab[i], 0));
      push("rtype_wb_r",  mk(S_WB_R,  2'b00, 1, 0, 1, 0, 2'b01, 2'b00, 2'b00, ALU_ADD, 0));
      repeat (4) begin
        sample(obs);
        exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s fn=%b: got %h want %h", tag, funct, obs, exp); end
      end
    end
  endtask

  task automatic test_i_type();
    logic [5:0] oc_tab[3] = '{OP_ADDI, OP_ORI, OP_SLTI};
    logic [1:0] sb_tab[3] = '{2'b01, 2'b10, 2'b01};
    logic [3:0] op_tab[3] = '{ALU_ADD, ALU_OR, ALU_SLT};
    rec_t obs, exp;
    string tag;
    for (int i = 0; i < 3; i++) begin
      opcode = oc_tab[i]; funct = 6'b101101;
      push_fetch_decode("itype");
      push("itype_exe_i", mk(S_EXE_I, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, sb_tab[i], op_tab[i], 0));
      push("itype_wb_i",  mk(S_WB_I,  2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
      repeat (4) begin
        sample(obs);
        exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s op=%b: got %h want %h", tag, opcode, obs, exp); end
      end
    end
  endtask

  task automatic test_load_store();
    rec_t obs, exp;
    string tag;
    opcode = OP_LW; funct = 6'b000000;
    push_fetch_decode("lw");
    push("lw_exe_ls", mk(S_EXE_LS, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, ALU_ADD, 0));
    push("lw_mem_rd", mk(S_MEM_RD, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
    push("lw_wb_ld",  mk(S_WB_LD,  2'b00, 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, ALU_ADD, 0));
    repeat (5) begin
      sample(obs);
      exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s: got %h want %h", tag, obs, exp); end
    end
    opcode = OP_SW;
    push_fetch_decode("sw");
    push("sw_exe_ls", mk(S_EXE_LS, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, ALU_ADD, 0));
    push("sw_mem_wr", mk(S_MEM_WR, 2'b00, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
    repeat (4) begin
      sample(obs);
      exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s: got %h want %h", tag, obs, exp); end
    end
  endtask

  task automatic test_branch();
    logic [5:0] oc_tab[4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       zf_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] pc_tab[4] = '{2'b10, 2'b00, 2'b10, 2'b00};
    rec_t obs, exp;
    string tag;
    for (int i = 0; i < 4; i++) begin
      opcode = oc_tab[i]; funct = 6'b100000; zf = zf_tab[i];
      push_fetch_decode("branch");
      push("branch_br", mk(S_BR, pc_tab[i], 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_SUB, 0));
      repeat (3) begin
        sample(obs);
        exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s op=%b zf=%b: got %h want %h", tag, opcode, zf, obs, exp); end
      end
    end
    zf = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] oc_tab[3] = '{OP_JAL, OP_J, OP_R};
    logic [1:0] pc_tab[3] = '{2'b11, 2'b11, 2'b01};
    logic       rw_tab[3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0] rd_tab[3] = '{2'b10, 2'b00, 2'b00};
    logic [1:0] wd_tab[3] = '{2'b10, 2'b00, 2'b00};
    rec_t obs, exp;
    string tag;
    for (int i = 0; i < 3; i++) begin
      opcode = oc_tab[i]; funct = FN_JR;
      push_fetch_decode("jump");
      push("jump_jmp", mk(S_JMP, pc_tab[i], 1, 0, rw_tab[i], 0, rd_tab[i], wd_tab[i], 2'b00, ALU_ADD, 0));
      repeat (3) begin
        sample(obs);
        exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s op=%b: got %h want %h", tag, opcode, obs, exp); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] oc_tab[2] = '{6'b111111, OP_R};
    rec_t obs, exp;
    string tag;
    for (int i = 0; i < 2; i++) begin
      opcode = oc_tab[i]; funct = 6'b111111;
      push_fetch_decode("illegal");
      push("illegal_err", mk(S_ERR, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 1));
      repeat (3) begin
        sample(obs);
        exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s op=%b: got %h want %h", tag, opcode, obs, exp); end
      end
    end
  endtask

  task automatic test_en_hold();
    rec_t obs, exp;
    string tag;
    opcode = OP_R; funct = FN_XOR;
    push_fetch_decode("en_xor");
    push("en_xor_exe_r", mk(S_EXE_R, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_XOR, 0));
    push("en_xor_wb_r",  mk(S_WB_R,  2'b00, 1, 0, 1, 0, 2'b01, 2'b00, 2'b00, ALU_ADD, 0));
    for (int i = 0; i < 4; i++)
      push("en_idle_fetch", mk(S_FETCH, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 0));
    for (int i = 0; i < 8; i++) begin
      sample(obs);
      if (i == 1) en = 1'b0;
      exp = sb.pop_front(); tag = tags.pop_front(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s cyc=%0d: got %h want %h", tag, i, obs, exp); end
    end
    en = 1'b1;
    #1;
    n_checks++;
    if (IR_write !== 1'b1 || state !== S_FETCH) begin
      n_fail++;
      $display("FAIL en_resume: got ir_write=%b state=%0d want ir_write=1 state=%0d", IR_write, state, S_FETCH);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; zf = 1'b0;
    opcode = OP_R; funct = FN_ADD;
    test_reset();
    test_r_type();
    test_i_type();
    test_load_store();
    test_branch();
    test_jump();
    test_illegal();
    test_en_hold();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drained: got %0d left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
